// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache controller.
package cache_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_SET_W  = 2;
   localparam int unsigned DEF_WAYS   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_EVICT,
      ST_FILL,
      ST_RESP,
      ST_FLUSH
   } state_t;

   // Ceiling log2, used to size the per-way age counters.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// True-LRU age storage for every set; age 0 is MRU, age WAYS-1 is the victim.
module cache_lru_ages
   import cache_pkg::*;
#(
   parameter int unsigned SET_W = DEF_SET_W,
   parameter int unsigned WAYS  = DEF_WAYS,
   parameter int unsigned AGE_W = clog2(DEF_WAYS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             touch_en,
   input  logic [SET_W-1:0] touch_set,
   input  logic [AGE_W-1:0] touch_way,
   input  logic             reset_ages,
   input  logic [SET_W-1:0] victim_set,
   output logic [AGE_W-1:0] victim_way
);

   localparam int unsigned SETS = 1 << SET_W;

   logic [AGE_W-1:0] age [SETS][WAYS];
   logic [AGE_W-1:0] touch_age;

   // Current age of the way being touched.
   always_comb begin
      touch_age = age[touch_set][touch_way];
   end

   // The victim is the single way holding the oldest age.
   always_comb begin
      victim_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (age[victim_set][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
      end
   end

   // Ages reset to the way index; a touch promotes to 0 and ages younger ways.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
               age[s][w] <= AGE_W'(w);
      end else if (reset_ages) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
               age[s][w] <= AGE_W'(w);
      end else if (touch_en) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touch_way)
               age[touch_set][w] <= '0;
            else if (age[touch_set][w] < touch_age)
               age[touch_set][w] <= age[touch_set][w] + AGE_W'(1);
         end
      end
   end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back, write-allocate cache controller with flush.
module assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned SET_W  = DEF_SET_W,
   parameter int unsigned WAYS   = DEF_WAYS
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_hit,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned AGE_W  = clog2(WAYS);
   localparam int unsigned TAG_W  = ADDR_W - SET_W;
   localparam int unsigned SETS   = 1 << SET_W;
   localparam int unsigned FIDX_W = SET_W + AGE_W;

   state_t state, state_nx;

   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [AGE_W-1:0]  way_q;
   logic [FIDX_W-1:0] fidx;
   logic [DATA_W-1:0] rdata_q;
   logic              hit_q;
   logic              flush_done_q;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS];

   logic [SET_W-1:0]  set_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [SET_W-1:0]  fset;
   logic [AGE_W-1:0]  fway;
   logic              hit;
   logic [AGE_W-1:0]  hit_way;
   logic              has_inv;
   logic [AGE_W-1:0]  inv_way;
   logic [AGE_W-1:0]  lru_way;
   logic [AGE_W-1:0]  victim;
   logic              vict_dirty;
   logic              touch_en;
   logic [AGE_W-1:0]  touch_way;
   logic              ages_rst;
   logic              flush_adv;

   assign set_idx    = addr_q[SET_W-1:0];
   assign req_tag    = addr_q[ADDR_W-1:SET_W];
   assign fset       = fidx[FIDX_W-1:AGE_W];
   assign fway       = fidx[AGE_W-1:0];
   assign victim     = has_inv ? inv_way : lru_way;
   assign vict_dirty = valid_q[set_idx][victim] && dirty_q[set_idx][victim];

   assign rsp_rdata  = rdata_q;
   assign rsp_hit    = hit_q;
   assign flush_done = flush_done_q;

   cache_lru_ages #(
      .SET_W (SET_W),
      .WAYS  (WAYS),
      .AGE_W (AGE_W)
   ) u_lru (
      .clk        (clk),
      .clr        (clr),
      .touch_en   (touch_en),
      .touch_set  (set_idx),
      .touch_way  (touch_way),
      .reset_ages (ages_rst),
      .victim_set (set_idx),
      .victim_way (lru_way)
   );

   // Tag match across the set and lowest-index invalid way.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
         if (!valid_q[set_idx][w] && !has_inv) begin
            has_inv = 1'b1;
            inv_way = AGE_W'(w);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state, handshake outputs, LRU touch and flush-scan advance.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      touch_en  = 1'b0;
      touch_way = '0;
      ages_rst  = 1'b0;
      flush_adv = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (flush_req) state_nx = ST_FLUSH;
            else begin
               req_ready = 1'b1;
               if (req_valid) state_nx = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (hit) begin
               touch_en  = 1'b1;
               touch_way = hit_way;
               state_nx  = ST_RESP;
            end else if (vict_dirty) begin
               state_nx = ST_EVICT;
            end else if (!rw_q) begin
               state_nx = ST_FILL;
            end else begin
               touch_en  = 1'b1;
               touch_way = victim;
               state_nx  = ST_RESP;
            end
         end
         ST_EVICT: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[set_idx][way_q], set_idx};
            mem_wdata = data_q[set_idx][way_q];
            if (mem_ack) begin
               if (rw_q) begin
                  touch_en  = 1'b1;
                  touch_way = way_q;
                  state_nx  = ST_RESP;
               end else begin
                  state_nx = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ack) begin
               touch_en  = 1'b1;
               touch_way = way_q;
               state_nx  = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            state_nx  = ST_IDLE;
         end
         ST_FLUSH: begin
            if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {tag_q[fset][fway], fset};
               mem_wdata = data_q[fset][fway];
               flush_adv = mem_ack;
            end else begin
               flush_adv = 1'b1;
            end
            if (flush_adv && fidx == '1) begin
               ages_rst = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Request capture, line arrays, response registers and flush scan.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         way_q        <= '0;
         fidx         <= '0;
         rdata_q      <= '0;
         hit_q        <= 1'b0;
         flush_done_q <= 1'b0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               data_q[s][w] <= '0;
            end
         end
      end else begin
         flush_done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               fidx <= '0;
               if (!flush_req && req_valid) begin
                  rw_q    <= req_rw;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
               end
            end
            ST_LOOKUP: begin
               way_q <= victim;
               if (hit) begin
                  hit_q <= 1'b1;
                  if (rw_q) begin
                     data_q[set_idx][hit_way]  <= wdata_q;
                     dirty_q[set_idx][hit_way] <= 1'b1;
                     rdata_q                   <= wdata_q;
                  end else begin
                     rdata_q <= data_q[set_idx][hit_way];
                  end
               end else if (!vict_dirty && rw_q) begin
                  tag_q[set_idx][victim]   <= req_tag;
                  data_q[set_idx][victim]  <= wdata_q;
                  valid_q[set_idx][victim] <= 1'b1;
                  dirty_q[set_idx][victim] <= 1'b1;
                  rdata_q                  <= wdata_q;
                  hit_q                    <= 1'b0;
               end
            end
            ST_EVICT: begin
               if (mem_ack) begin
                  // A write miss installs over the evicted way in the same cycle, so dirty ends up set.
                  dirty_q[set_idx][way_q] <= 1'b0;
                  if (rw_q) begin
                     tag_q[set_idx][way_q]   <= req_tag;
                     data_q[set_idx][way_q]  <= wdata_q;
                     valid_q[set_idx][way_q] <= 1'b1;
                     dirty_q[set_idx][way_q] <= 1'b1;
                     rdata_q                 <= wdata_q;
                     hit_q                   <= 1'b0;
                  end
               end
            end
            ST_FILL: begin
               if (mem_ack) begin
                  tag_q[set_idx][way_q]   <= req_tag;
                  data_q[set_idx][way_q]  <= mem_rdata;
                  valid_q[set_idx][way_q] <= 1'b1;
                  dirty_q[set_idx][way_q] <= 1'b0;
                  rdata_q                 <= mem_rdata;
                  hit_q                   <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (flush_adv) begin
                  valid_q[fset][fway] <= 1'b0;
                  dirty_q[fset][fway] <= 1'b0;
                  fidx                <= fidx + FIDX_W'(1);
                  if (fidx == '1) flush_done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl with a behavioural backing memory.
module tb_assoc_cache_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_hit;
   logic       flush_req;
   logic       flush_done;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;

   always #5 clk = ~clk;

   assoc_cache_ctrl #(
      .ADDR_W (8),
      .DATA_W (8),
      .SET_W  (2),
      .WAYS   (4)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_hit    (rsp_hit),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;
   int unsigned wcnt = 0;
   int unsigned nacc = 0;
   int unsigned nfd = 0;
   int unsigned rsp_cyc = 0;
   int unsigned acc_cyc = 0;
   int unsigned fd_cyc = 0;
   int unsigned a0, f0, t0, dur;
   logic        got_rsp;
   logic [7:0]  rsp_d;
   logic        rsp_h;

   logic [7:0]  bmem [256];
   logic        log_we [64];
   logic [7:0]  log_addr [64];
   logic [7:0]  log_wdata [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, answer memory requests on their second cycle.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req) begin
         if (wcnt == 1) begin
            mem_ack   = 1'b1;
            mem_rdata = bmem[mem_addr];
            if (mem_we) bmem[mem_addr] = mem_wdata;
            if (nacc < 64) begin
               log_we[nacc]    = mem_we;
               log_addr[nacc]  = mem_addr;
               log_wdata[nacc] = mem_wdata;
            end
            nacc++;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end
      if (rsp_valid) begin
         got_rsp = 1'b1;
         rsp_d   = rsp_rdata;
         rsp_h   = rsp_hit;
         rsp_cyc = cyc;
      end
      if (flush_done) begin
         nfd++;
         fd_cyc = cyc;
      end
   endtask

   task automatic do_req(input logic rw, input logic [7:0] a, input logic [7:0] wd);
      int unsigned n;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = wd;
      got_rsp   = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      req_valid = 1'b0;
      acc_cyc = cyc;
      n = 0;
      while (!got_rsp && n < 200) begin
         tick();
         n++;
      end
      chk("rsp_seen", got_rsp, 1'b1);
      tick();
      chk("rsp_one_cycle", rsp_valid, 1'b0);
   endtask

   task automatic do_flush(output int unsigned d);
      int unsigned n;
      int unsigned start;
      start = cyc;
      flush_req = 1'b1;
      #1;
      chk("ready_low_on_flush", req_ready, 1'b0);
      tick();
      flush_req = 1'b0;
      f0 = nfd;
      n = 0;
      while (nfd == f0 && n < 300) begin
         tick();
         n++;
      end
      d = fd_cyc - start;
      tick();
      tick();
      chk("flush_done_once", nfd - f0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b0;
      req_valid = 1'b0;
      req_rw = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      flush_req = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      got_rsp = 1'b0;
      rsp_d = '0;
      rsp_h = 1'b0;
      for (int i = 0; i < 256; i++) bmem[i] = 8'(i) ^ 8'hA0;
      #2 clr = 1'b1;
      #2;
      // reset values
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_hit", rsp_hit, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      chk("rst_flush_done", flush_done, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      tick();
      tick();
      clr = 1'b0;
      tick();

      // clean flush: 16 scan cycles then flush_done
      a0 = nacc;
      do_flush(dur);
      chk("clean_flush_cycles", dur, 17);
      chk("clean_flush_no_mem", nacc - a0, 0);

      // 1: read miss with fill, then hit
      a0 = nacc;
      do_req(1'b0, 8'h0F, 8'h00);
      chk("t1_miss_rdata", rsp_d, 8'hAF);
      chk("t1_miss_hit", rsp_h, 1'b0);
      chk("t1_miss_nacc", nacc - a0, 1);
      chk("t1_fill_addr", log_addr[a0], 8'h0F);
      chk("t1_fill_we", log_we[a0], 1'b0);
      chk("t1_miss_latency", rsp_cyc - acc_cyc, 3);
      a0 = nacc;
      do_req(1'b0, 8'h0F, 8'h00);
      chk("t1_hit_hit", rsp_h, 1'b1);
      chk("t1_hit_rdata", rsp_d, 8'hAF);
      chk("t1_hit_nacc", nacc - a0, 0);
      chk("t1_hit_latency", rsp_cyc - acc_cyc, 1);

      // 2: write-allocate without memory access
      a0 = nacc;
      do_req(1'b1, 8'h01, 8'hE0);
      chk("t2_wr_hit", rsp_h, 1'b0);
      chk("t2_wr_rdata", rsp_d, 8'hE0);
      chk("t2_wr_nacc", nacc - a0, 0);
      do_req(1'b0, 8'h01, 8'h00);
      chk("t2_rd_hit", rsp_h, 1'b1);
      chk("t2_rd_rdata", rsp_d, 8'hE0);

      // 3: LRU victim selection in set 1
      do_req(1'b0, 8'h05, 8'h00);
      do_req(1'b0, 8'h09, 8'h00);
      do_req(1'b0, 8'h0D, 8'h00);
      do_req(1'b0, 8'h01, 8'h00);
      chk("t3_touch_hit", rsp_h, 1'b1);
      a0 = nacc;
      do_req(1'b0, 8'h11, 8'h00);
      chk("t3_miss_hit", rsp_h, 1'b0);
      chk("t3_miss_rdata", rsp_d, 8'hB1);
      chk("t3_nacc", nacc - a0, 1);
      chk("t3_fill_addr", log_addr[a0], 8'h11);
      chk("t3_fill_we", log_we[a0], 1'b0);
      do_req(1'b0, 8'h01, 8'h00);
      chk("t3_mru_kept", rsp_h, 1'b1);
      do_req(1'b0, 8'h05, 8'h00);
      chk("t3_victim_gone", rsp_h, 1'b0);

      // 4: dirty victim write-back before fill
      a0 = nacc;
      do_req(1'b1, 8'h02, 8'h12);
      do_req(1'b1, 8'h06, 8'h16);
      do_req(1'b1, 8'h0A, 8'h1A);
      do_req(1'b1, 8'h0E, 8'h1E);
      chk("t4_writes_nacc", nacc - a0, 0);
      do_req(1'b0, 8'hAA, 8'h00);
      chk("t4_nacc", nacc - a0, 2);
      chk("t4_wb_we", log_we[a0], 1'b1);
      chk("t4_wb_addr", log_addr[a0], 8'h02);
      chk("t4_wb_wdata", log_wdata[a0], 8'h12);
      chk("t4_fill_we", log_we[a0+1], 1'b0);
      chk("t4_fill_addr", log_addr[a0+1], 8'hAA);
      chk("t4_rdata", rsp_d, 8'h0A);
      chk("t4_hit", rsp_h, 1'b0);

      // 5a: flush the four dirty lines left so far
      a0 = nacc;
      do_flush(dur);
      chk("t5a_nacc", nacc - a0, 4);
      chk("t5a_wb0_addr", log_addr[a0], 8'h01);
      chk("t5a_wb0_data", log_wdata[a0], 8'hE0);
      chk("t5a_wb1_addr", log_addr[a0+1], 8'h06);
      chk("t5a_wb2_addr", log_addr[a0+2], 8'h0A);
      chk("t5a_wb3_addr", log_addr[a0+3], 8'h0E);
      chk("t5a_wb3_data", log_wdata[a0+3], 8'h1E);

      // 5b: exactly three dirty lines, flushed in set/way order
      do_req(1'b1, 8'h13, 8'h33);
      do_req(1'b1, 8'h04, 8'h44);
      do_req(1'b1, 8'h07, 8'h77);
      a0 = nacc;
      do_flush(dur);
      chk("t5b_nacc", nacc - a0, 3);
      chk("t5b_wb0", {log_we[a0], log_addr[a0], log_wdata[a0]}, {1'b1, 8'h04, 8'h44});
      chk("t5b_wb1", {log_we[a0+1], log_addr[a0+1], log_wdata[a0+1]}, {1'b1, 8'h13, 8'h33});
      chk("t5b_wb2", {log_we[a0+2], log_addr[a0+2], log_wdata[a0+2]}, {1'b1, 8'h07, 8'h77});
      do_req(1'b0, 8'h13, 8'h00);
      chk("t5b_after_hit", rsp_h, 1'b0);
      chk("t5b_after_rdata", rsp_d, 8'h33);
      do_req(1'b0, 8'h0F, 8'h00);
      chk("t5b_after_0f_hit", rsp_h, 1'b0);

      // 6: reset during fill
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 8'h30;
      got_rsp   = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      chk("t6_fill_active", mem_req, 1'b1);
      clr = 1'b1;
      #1;
      chk("t6_mem_req_drop", mem_req, 1'b0);
      tick();
      tick();
      clr = 1'b0;
      wcnt = 0;
      tick();
      tick();
      chk("t6_no_rsp", got_rsp, 1'b0);
      chk("t6_no_flush_done", flush_done, 1'b0);
      chk("t6_ready", req_ready, 1'b1);
      do_req(1'b0, 8'h13, 8'h00);
      chk("t6_read_miss", rsp_h, 1'b0);
      chk("t6_read_rdata", rsp_d, 8'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
